// File: rtl/montexp_pkg.sv
// Shared definitions for the Montgomery exponentiation sequencer:
// the FSM state encoding, the modulus-select codes and the width constants.
package montexp_pkg;

  // Default widths. Operand buses carry PAD_BITS of headroom above the
  // modulus so that intermediate Montgomery values do not overflow.
  localparam int M_LENGTH_DEF   = 512;
  localparam int EXP_LENGTH_DEF = 256;
  localparam int PAD_BITS       = 16;

  // Modulus selection codes understood by the Montgomery multiplier.
  localparam logic [1:0] MSEL_N2        = 2'b00;
  localparam logic [1:0] MSEL_N2_PLUS_2 = 2'b01;
  localparam logic [1:0] MSEL_N         = 2'b10;

  // Left-to-right square-and-multiply sequencer states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SQ_ISSUE  = 3'd1,
    SQ_WAIT   = 3'd2,
    MUL_ISSUE = 3'd3,
    MUL_WAIT  = 3'd4,
    FINISH    = 3'd5
  } state_e;

  // True in the single cycle where a multiplier start is issued.
  function automatic logic is_issue(input state_e s);
    return (s == SQ_ISSUE) || (s == MUL_ISSUE);
  endfunction

  // True while the multiplier works on acc * base rather than acc * acc.
  function automatic logic is_mul_phase(input state_e s);
    return (s == MUL_ISSUE) || (s == MUL_WAIT);
  endfunction

endpackage

// File: rtl/mont_exp_seq.sv
// Montgomery modular exponentiation sequencer (left-to-right binary method).
// Drives an external Montgomery multiplier through the mm_* ports: one
// square per exponent bit, plus one multiply by the base for each set bit.
//
// Optional build macro MONTEXP_SKIP_LZ_EN: when defined, leading zero
// exponent bits are skipped (processing starts at the highest set bit and
// an all-zero exponent finishes immediately with result = one_mont). When
// undefined, all EXP_LENGTH bits are processed.
module mont_exp_seq
  import montexp_pkg::*;
#(
  parameter int M_LENGTH   = M_LENGTH_DEF,
  parameter int EXP_LENGTH = EXP_LENGTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic [M_LENGTH+15:0]     base,
  input  logic [EXP_LENGTH-1:0]    exponent,
  input  logic [M_LENGTH+15:0]     one_mont,
  input  logic [1:0]               m_sel,
  output logic                     busy,
  output logic                     valid,
  output logic [M_LENGTH+15:0]     result,
  output logic                     mm_start,
  output logic [M_LENGTH+15:0]     mm_multiplier,
  output logic [M_LENGTH+15:0]     mm_multiplicand,
  output logic [1:0]               mm_m_select,
  input  logic                     mm_done,
  input  logic [M_LENGTH+15:0]     mm_product
);

  localparam int W  = M_LENGTH + PAD_BITS;
  localparam int IW = (EXP_LENGTH > 1) ? $clog2(EXP_LENGTH) : 1;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    base_q, base_d;
  logic [W-1:0]    result_q, result_d;
  logic [EXP_LENGTH-1:0] exp_q, exp_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      msel_q, msel_d;

`ifdef MONTEXP_SKIP_LZ_EN
  // Index of the most significant set bit; 0 when the exponent is zero.
  function automatic logic [IW-1:0] msb_index(input logic [EXP_LENGTH-1:0] e);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < EXP_LENGTH; i++) begin
      if (e[i]) idx = IW'(i);
    end
    return idx;
  endfunction
`endif

  // State and datapath registers; everything clears on reset, including acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      base_q   <= '0;
      result_q <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      msel_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      result_q <= result_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      msel_q   <= msel_d;
    end
  end

  // Next-state and datapath update for the square-and-multiply walk.
  always_comb begin
    // NOTE: every variable is defaulted to its held value first, so no
    // path through the case statement can infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    result_d = result_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    msel_d   = msel_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          base_d = base;
          exp_d  = exponent;
          msel_d = m_sel;
          acc_d  = one_mont;
`ifdef MONTEXP_SKIP_LZ_EN
          if (exponent == '0) begin
            // Nothing to do: x^0 is one in Montgomery form.
            state_d  = FINISH;
            result_d = one_mont;
          end else begin
            idx_d   = msb_index(exponent);
            state_d = SQ_ISSUE;
          end
`else
          idx_d   = IW'(EXP_LENGTH - 1);
          state_d = SQ_ISSUE;
`endif
        end
      end

      SQ_ISSUE: state_d = SQ_WAIT;

      SQ_WAIT: begin
        if (mm_done) begin
          acc_d = mm_product;
          if (exp_q[idx_q]) begin
            state_d = MUL_ISSUE;
          end else if (idx_q == '0) begin
            state_d  = FINISH;
            result_d = mm_product;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = SQ_ISSUE;
          end
        end
      end

      MUL_ISSUE: state_d = MUL_WAIT;

      MUL_WAIT: begin
        if (mm_done) begin
          acc_d = mm_product;
          if (idx_q == '0) begin
            state_d  = FINISH;
            result_d = mm_product;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = SQ_ISSUE;
          end
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state, so reset clears them at once.
  assign busy            = (state_q != IDLE);
  assign valid           = (state_q == FINISH);
  assign result          = result_q;
  assign mm_start        = is_issue(state_q);
  assign mm_multiplier   = acc_q;
  assign mm_multiplicand = is_mul_phase(state_q) ? base_q : acc_q;
  assign mm_m_select     = msel_q;

endmodule

// File: tb/tb_mont_exp_seq.sv
// Directed testbench for mont_exp_seq with a behavioural Montgomery
// multiplier: modulus 13, R = 16 (R mod 13 = 3, R^-1 mod 13 = 9), so
// mont(a, b) = a * b * 9 mod 13. Base x = 2 -> base_mont = 6,
// one_mont = 3, x^5 = 32 = 6 mod 13 -> Montgomery form 6*16 mod 13 = 5.
module tb_mont_exp_seq;
  import montexp_pkg::*;

  localparam int M_LENGTH   = 512;
  localparam int EXP_LENGTH = 256;
  localparam int W          = M_LENGTH + 16;

  localparam logic [W-1:0] ONE_M  = W'(3);
  localparam logic [W-1:0] BASE_M = W'(6);
  localparam logic [W-1:0] POW5_M = W'(5);

`ifdef MONTEXP_SKIP_LZ_EN
  localparam int E0_STARTS = 0,   E0_SQ = 0;
  localparam int E1_STARTS = 2,   E1_SQ = 1;
  localparam int E5_STARTS = 5,   E5_SQ = 3;
`else
  localparam int E0_STARTS = 256, E0_SQ = 256;
  localparam int E1_STARTS = 257, E1_SQ = 256;
  localparam int E5_STARTS = 258, E5_SQ = 256;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req;
  logic [W-1:0]          base;
  logic [EXP_LENGTH-1:0] exponent;
  logic [W-1:0]          one_mont;
  logic [1:0]            m_sel;
  logic                  busy, valid, mm_start;
  logic [W-1:0]          result, mm_multiplier, mm_multiplicand;
  logic [1:0]            mm_m_select;
  logic                  mm_done = 1'b1;
  logic [W-1:0]          mm_product = W'(7);

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0, n_eq = 0, n_valid = 0, n_consec = 0;
  int s_start, s_eq, s_valid;

  mont_exp_seq #(.M_LENGTH(M_LENGTH), .EXP_LENGTH(EXP_LENGTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .base(base), .exponent(exponent),
    .one_mont(one_mont), .m_sel(m_sel), .busy(busy), .valid(valid),
    .result(result), .mm_start(mm_start), .mm_multiplier(mm_multiplier),
    .mm_multiplicand(mm_multiplicand), .mm_m_select(mm_m_select),
    .mm_done(mm_done), .mm_product(mm_product)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = (longint'(a[15:0]) * longint'(b[15:0]) * 64'd9) % 64'd13;
    return W'(p);
  endfunction

  // Behavioural multiplier: done drops on start, product after 3 cycles.
  logic [W-1:0] op_a, op_b;
  int           lat = 0;
  bit           prev_start = 1'b0;
  always @(posedge clk) begin
    if (mm_start) begin
      op_a    <= mm_multiplier;
      op_b    <= mm_multiplicand;
      mm_done <= 1'b0;
      lat     <= 3;
      n_start = n_start + 1;
      if (mm_multiplier == mm_multiplicand) n_eq = n_eq + 1;
    end else if (!mm_done) begin
      if (lat == 1) begin
        mm_product <= mont(op_a, op_b);
        mm_done    <= 1'b1;
      end else begin
        lat <= lat - 1;
      end
    end
    if (mm_start && prev_start) n_consec = n_consec + 1;
    prev_start = mm_start;
    if (valid) n_valid = n_valid + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic snapshot();
    s_start = n_start;
    s_eq    = n_eq;
    s_valid = n_valid;
  endtask

  // Pulses req for one cycle; returns #1 after the edge that consumed it.
  task automatic drive_req(input logic [W-1:0] b, input logic [EXP_LENGTH-1:0] e,
                           input logic [W-1:0] one, input logic [1:0] ms);
    base     = b;
    exponent = e;
    one_mont = one;
    m_sel    = ms;
    req      = 1'b1;
    @(posedge clk); #1;
    req      = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit hit;
    hit = valid;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      hit = valid;
    end
    check({tag, "_valid_seen"}, W'(hit), W'(1));
  endtask

  // Steps one cycle past FINISH, then checks counts for the completed run.
  task automatic check_run(input string tag, input logic [W-1:0] want_res,
                           input int want_starts, input int want_sq);
    @(posedge clk); #1;
    check({tag, "_result"}, result, want_res);
    check({tag, "_starts"}, W'(n_start - s_start), W'(want_starts));
    check({tag, "_squares"}, W'(n_eq - s_eq), W'(want_sq));
    check({tag, "_valid_pulses"}, W'(n_valid - s_valid), W'(1));
    check({tag, "_idle"}, W'({busy, valid}), W'(0));
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0; req = 1'b0; base = '0; exponent = '0; one_mont = '0; m_sel = '0;
    #3;
    check("rst_busy", W'(busy), W'(0));
    check("rst_valid", W'(valid), W'(0));
    check("rst_mm_start", W'(mm_start), W'(0));
    check("rst_result", result, W'(0));
    check("rst_multiplier", mm_multiplier, W'(0));
    check("rst_multiplicand", mm_multiplicand, W'(0));
    check("rst_m_select", W'(mm_m_select), W'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // exponent = 0: squarings only, result is one_mont.
    snapshot();
    drive_req(BASE_M, '0, ONE_M, MSEL_N);
    wait_valid("exp0", 3000);
    check("exp0_result_at_valid", result, ONE_M);
    check_run("exp0", ONE_M, E0_STARTS, E0_SQ);

    // exponent = 1 while mm_done idles high with a stale product of 7.
    snapshot();
    drive_req(BASE_M, EXP_LENGTH'(1), ONE_M, MSEL_N);
    check("exp1_first_start", W'(mm_start), W'(1));
    check("exp1_first_operand", mm_multiplier, ONE_M);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      hit = mm_start;
    end
    check("exp1_second_start_seen", W'(hit), W'(1));
    check("exp1_no_early_capture", mm_multiplier, mont(ONE_M, ONE_M));
    check("exp1_m_select", W'(mm_m_select), W'(MSEL_N));
    wait_valid("exp1", 3000);
    check_run("exp1", BASE_M, E1_STARTS, E1_SQ);

    // exponent = 5 with a conflicting req issued mid-run.
    snapshot();
    drive_req(BASE_M, EXP_LENGTH'(5), ONE_M, MSEL_N);
    repeat (10) begin @(posedge clk); #1; end
    check("busy_mid_run", W'(busy), W'(1));
    drive_req(W'(99), '0, W'(0), MSEL_N2_PLUS_2);
    check("ignored_req_m_select", W'(mm_m_select), W'(MSEL_N));
    wait_valid("exp5", 3000);
    check_run("exp5", POW5_M, E5_STARTS, E5_SQ);

    // Reset while the multiply for exponent = 1 is in flight.
    drive_req(BASE_M, EXP_LENGTH'(1), ONE_M, MSEL_N2);
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge clk); #1;
      hit = mm_start && (mm_multiplicand == BASE_M) && (mm_multiplier != BASE_M);
    end
    check("mul_issue_seen", W'(hit), W'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_mm_start", W'(mm_start), W'(0));
    check("midrst_result", result, W'(0));
    check("midrst_operand", mm_multiplicand, W'(0));
    @(negedge clk) rst_n = 1'b1;
    snapshot();
    repeat (20) begin @(posedge clk); #1; end
    check("post_rst_idle", W'({busy, valid}), W'(0));
    check("post_rst_no_start", W'(n_start - s_start), W'(0));
    check("post_rst_no_valid", W'(n_valid - s_valid), W'(0));

    // A fresh request after the reset runs to a correct result.
    snapshot();
    drive_req(BASE_M, EXP_LENGTH'(5), ONE_M, MSEL_N);
    wait_valid("rerun5", 3000);
    check_run("rerun5", POW5_M, E5_STARTS, E5_SQ);

    check("no_back_to_back_start", W'(n_consec), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
